glove_region_detector: RTL and testbench

- Scans the camera pixel stream and classifies each pixel as glove or not glove using an RGB colour key.
- Counts glove pixels in four vertical screen regions, each 160 columns wide, over a whole 640x480 frame.
- At each frame end, produces debounced per-region presence flags.
- It is the producer of the red/green/blue/yellow region flags consumed by the overlay renderer that draws the highlighted region rectangle.

---
 rtl/glove_region_detector.sv | 145 ++++++++++++++
 tb/tb_glove_region_detector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/glove_region_detector.sv
// Glove region detector: colour-keys each pixel of the camera stream, counts
// glove pixels in four 160-column regions per frame, and raises debounced
// per-region presence flags at every frame end.

// Per-region accumulator: saturating glove-pixel counter, frame-close
// threshold test, and persistence debounce that drives one presence flag.
module glove_region_acc #(
   parameter int          COUNT_W   = 17,
   parameter int unsigned THRESHOLD = 2000,
   parameter int          PERSIST   = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic hit_i,    // stage-1 pixel hit routed to this region
   input  logic close_i,  // stage-1 copy of frame_end
   output logic flag_o
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] THR     = COUNT_W'(THRESHOLD);
   localparam logic [1:0]         PC_MAX  = 2'(PERSIST);

   logic [COUNT_W-1:0] cnt_q, cnt_d, total;
   logic [COUNT_W:0]   sum;
   logic [1:0]         pc_q, pc_d;
   logic               flag_q, flag_d;

   // Next-state: the pixel arriving with the close pulse still belongs to
   // the closing frame, so the threshold test sees counter + this hit.
   always_comb begin
      sum    = {1'b0, cnt_q} + {{COUNT_W{1'b0}}, hit_i};
      total  = sum[COUNT_W] ? CNT_MAX : sum[COUNT_W-1:0];
      cnt_d  = total;
      pc_d   = pc_q;
      flag_d = flag_q;
      if (close_i) begin
         cnt_d = '0;
         if (total >= THR)
            pc_d = (pc_q >= PC_MAX) ? PC_MAX : pc_q + 2'd1;
         else
            pc_d = '0;
         flag_d = (pc_d == PC_MAX);
      end
   end

   // Counter, persistence and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         pc_q   <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pc_q   <= pc_d;
         flag_q <= flag_d;
      end
   end

   assign flag_o = flag_q;

endmodule

module glove_region_detector #(
   parameter logic [7:0]  R_MIN     = 8'd150,
   parameter logic [7:0]  G_MAX     = 8'd90,
   parameter logic [7:0]  B_MAX     = 8'd90,
   parameter int unsigned THRESHOLD = 2000,
   parameter int          PERSIST   = 2,
   parameter int          COUNT_W   = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pixel_valid,
   input  logic [7:0] R,
   input  logic [7:0] G,
   input  logic [7:0] B,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic       frame_end,
   output logic       red_flag,
   output logic       green_flag,
   output logic       blue_flag,
   output logic       yellow_flag,
   output logic       flags_valid
);

   localparam int NUM_REG = 4;

   logic       s1_hit_q, s1_hit_d;
   logic [1:0] s1_reg_q, s1_reg_d;
   logic       s1_fe_q;
   logic       flags_valid_q;
   logic [NUM_REG-1:0] flag_w;

   // Stage-1 classification: colour key plus on-screen check, and region pick.
   always_comb begin
      s1_hit_d = pixel_valid && (x_pos < 10'd640) && (y_pos < 10'd480) &&
                 (R >= R_MIN) && (G <= G_MAX) && (B <= B_MAX);
      if (x_pos < 10'd160)      s1_reg_d = 2'd0;
      else if (x_pos < 10'd320) s1_reg_d = 2'd1;
      else if (x_pos < 10'd480) s1_reg_d = 2'd2;
      else                      s1_reg_d = 2'd3;
   end

   // Stage-1 registers; frame_end travels alongside its pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_hit_q <= 1'b0;
         s1_reg_q <= 2'd0;
         s1_fe_q  <= 1'b0;
      end else begin
         s1_hit_q <= s1_hit_d;
         s1_reg_q <= s1_reg_d;
         s1_fe_q  <= frame_end;
      end
   end

   // One accumulator per screen region.
   for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_reg
      glove_region_acc #(
         .COUNT_W  (COUNT_W),
         .THRESHOLD(THRESHOLD),
         .PERSIST  (PERSIST)
      ) u_acc (
         .clk    (clk),
         .reset  (reset),
         .hit_i  (s1_hit_q && (s1_reg_q == 2'(gi))),
         .close_i(s1_fe_q),
         .flag_o (flag_w[gi])
      );
   end

   // Update strobe: pulses on the edge where the flags were just rewritten.
   always_ff @(posedge clk) begin
      if (reset) flags_valid_q <= 1'b0;
      else       flags_valid_q <= s1_fe_q;
   end

   assign red_flag    = flag_w[0];
   assign green_flag  = flag_w[1];
   assign blue_flag   = flag_w[2];
   assign yellow_flag = flag_w[3];
   assign flags_valid = flags_valid_q;

endmodule

// File: tb/tb_glove_region_detector.sv
// Bench for glove_region_detector: three instances (PERSIST 2/1/3, THRESHOLD
// 100) share one stimulus stream; a frame-level reference model predicts the
// flags and strobe two cycles after each frame end.
module tb_glove_region_detector;

   localparam int NI = 3;
   localparam int THR = 100;
   localparam int PERS [NI] = '{2, 1, 3};

   logic       clk = 1'b0;
   logic       reset, pixel_valid, frame_end;
   logic [7:0] R, G, B;
   logic [9:0] x_pos, y_pos;
   logic [3:0] flg [NI];
   logic       fv  [NI];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic rf, gf, bf, yf, vf;
      glove_region_detector #(.THRESHOLD(THR), .PERSIST(PERS[gi])) u_dut (
         .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
         .R(R), .G(G), .B(B), .x_pos(x_pos), .y_pos(y_pos),
         .frame_end(frame_end),
         .red_flag(rf), .green_flag(gf), .blue_flag(bf), .yellow_flag(yf),
         .flags_valid(vf)
      );
      assign flg[gi] = {yf, bf, gf, rf};
      assign fv[gi]  = vf;
   end

   // reference model state
   int         cnt [4];
   int         pc  [NI][4];
   logic [3:0] hold [NI];
   logic [3:0] d1f [NI];
   logic [3:0] d2f [NI];
   logic       d1v, d2v;
   bit         chk_en;
   int         n_tests, n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: drive, check at negedge, advance the model
   task automatic cyc(input bit rst, input bit pv, input int r, input int g, input int b,
                      input int x, input int y, input bit fe);
      bit         hit;
      logic [3:0] nf [NI];
      reset = rst; pixel_valid = pv; frame_end = fe;
      R = 8'(r); G = 8'(g); B = 8'(b); x_pos = 10'(x); y_pos = 10'(y);
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            if (d2v) hold[i] = d2f[i];
            chk($sformatf("valid%0d", i), 32'(fv[i]), 32'(d2v));
            chk($sformatf("flags%0d", i), 32'(flg[i]), 32'(hold[i]));
         end
      end
      if (rst) begin
         for (int k = 0; k < 4; k++) cnt[k] = 0;
         for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4; k++) pc[i][k] = 0;
            hold[i] = '0; d1f[i] = '0; d2f[i] = '0;
         end
         d1v = 1'b0; d2v = 1'b0; chk_en = 1'b1;
      end else begin
         hit = pv && x < 640 && y < 480 && r >= 150 && g <= 90 && b <= 90;
         if (hit && cnt[x / 160] < 131071) cnt[x / 160]++;
         for (int i = 0; i < NI; i++) begin
            nf[i] = '0;
            if (fe)
               for (int k = 0; k < 4; k++) begin
                  if (cnt[k] >= THR) pc[i][k] = (pc[i][k] + 1 > PERS[i]) ? PERS[i] : pc[i][k] + 1;
                  else               pc[i][k] = 0;
                  nf[i][k] = (pc[i][k] == PERS[i]);
               end
         end
         if (fe) for (int k = 0; k < 4; k++) cnt[k] = 0;
         d2v = d1v; d1v = fe;
         for (int i = 0; i < NI; i++) begin d2f[i] = d1f[i]; d1f[i] = nf[i]; end
      end
      @(posedge clk); #1;
   endtask

   task automatic gp(input int x, input int y, input bit fe);
      cyc(0, 1, 200, 50, 50, x, y, fe);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // frame end followed by enough idle cycles for the flags to settle
   task automatic close_frame();
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);
   endtask

   task automatic rnd_pixel(input int breg, input bit fe);
      int r, g, b, x, y;
      if ($urandom_range(0, 1) == 1) begin
         r = $urandom_range(145, 255); g = $urandom_range(0, 95); b = $urandom_range(0, 95);
      end else begin
         r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 9) < 7) x = breg * 160 + $urandom_range(0, 159);
      else                          x = $urandom_range(0, 700);
      y = $urandom_range(0, 490);
      cyc(0, $urandom_range(0, 7) != 0, r, g, b, x, y, fe);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; chk_en = 1'b0;
      d1v = 1'b0; d2v = 1'b0;

      // reset with random inputs, then an empty frame
      for (int i = 0; i < 2; i++)
         cyc(1, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 1));
      idle(2);
      close_frame();
      chk("empty_flags", 32'(flg[0]), 32'h0);

      // persistence: two hit frames needed with PERSIST=2, a miss clears
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 150; i++) gp(50, i, 0);
         close_frame();
         chk($sformatf("persist_red_f%0d", f), 32'(flg[0][0]), 32'(f));
      end
      close_frame();
      chk("miss_red", 32'(flg[0][0]), 32'h0);

      // region boundary split and 99-pixel miss
      for (int i = 0; i < 100; i++) gp(159, i, 0);
      for (int i = 0; i < 100; i++) gp(160, i, 0);
      for (int i = 0; i < 99; i++)  gp(330, i, 0);
      close_frame();
      chk("split_flags", 32'(flg[1]), 32'h3);

      // 100th pixel coincides with frame_end
      for (int i = 0; i < 99; i++) gp(500, i, 0);
      gp(500, 99, 1);
      idle(2);
      chk("coincident_yellow", 32'(flg[1][3]), 32'h1);

      // out-of-range, off-colour and invalid pixels never count
      for (int i = 0; i < 120; i++) begin
         gp(640, i, 0);
         gp(20, 480, 0);
         cyc(0, 1, 149, 50, 50, 200, i, 0);
         cyc(0, 0, 200, 50, 50, 400, i, 0);
      end
      close_frame();
      for (int i = 0; i < NI; i++) chk($sformatf("reject_flags%0d", i), 32'(flg[i]), 32'h0);

      // reset mid-frame discards partial counts
      for (int i = 0; i < 80; i++) gp(50, i, 0);
      cyc(1, 1, 200, 50, 50, 50, 0, 0);
      for (int i = 0; i < 30; i++) gp(50, i, 0);
      close_frame();
      chk("midreset_red", 32'(flg[1][0]), 32'h0);

      // back-to-back frame ends
      for (int i = 0; i < 120; i++) gp(400, i, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);

      // randomized frames
      for (int f = 0; f < 45; f++) begin
         int len, breg;
         len  = $urandom_range(0, 420);
         breg = $urandom_range(0, 3);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 999) == 0) cyc(1, 0, 0, 0, 0, 0, 0, 0);
            else rnd_pixel(breg, 0);
         end
         if ($urandom_range(0, 1) == 1) rnd_pixel(breg, 1);
         else cyc(0, 0, 0, 0, 0, 0, 0, 1);
         if ($urandom_range(0, 4) == 0) cyc(0, 0, 0, 0, 0, 0, 0, 1);
         idle($urandom_range(0, 3));
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
